// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared constants for the PC sequencer slice.
//   - default widths (PC_W_DEF, OP_W_DEF)
//   - FSM state encodings ST_IF..ST_HALT (3-bit, legacy-compatible values)
//   - opcode constants OP_R..OP_HALT
//   - pc_sel_e: next-PC source select used by pc_next_calc
package pc_seq_pkg;

    localparam int PC_W_DEF = 6;
    localparam int OP_W_DEF = 6;

    localparam logic [2:0] ST_IF   = 3'd0;
    localparam logic [2:0] ST_ID   = 3'd1;
    localparam logic [2:0] ST_EX   = 3'd2;
    localparam logic [2:0] ST_MEM  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JMP  = 2'd2,
        SEL_HOLD = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the sequencer's decoder/PC-register side signals.
//   Inputs to sequencer : opcode, zero, stall, pc_cur, br_off, j_addr
//   Outputs of sequencer: pc_next, pc_we, ir_we, rf_we, mem_we, state, halt
//   modport master : sequencer view
//   modport slave  : core / datapath view
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int OP_W = OP_W_DEF
);

    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            stall;
    logic [PC_W-1:0] pc_cur;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] j_addr;
    logic [PC_W-1:0] pc_next;
    logic            pc_we;
    logic            ir_we;
    logic            rf_we;
    logic            mem_we;
    logic [2:0]      state;
    logic            halt;

    modport master (
        input  opcode, zero, stall, pc_cur, br_off, j_addr,
        output pc_next, pc_we, ir_we, rf_we, mem_we, state, halt
    );

    modport slave (
        output opcode, zero, stall, pc_cur, br_off, j_addr,
        input  pc_next, pc_we, ir_we, rf_we, mem_we, state, halt
    );

endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selector (PC_W-bit modulo arithmetic).
//   i_sel     : SEL_SEQ (pc+1), SEL_BR (pc+br_off), SEL_JMP (j_addr), SEL_HOLD (pc)
//   i_pc_cur  : current PC register value
//   i_br_off  : sign-extended branch offset
//   i_j_addr  : jump target
//   o_pc_next : selected next PC
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  pc_sel_e         i_sel,
    input  logic [PC_W-1:0] i_pc_cur,
    input  logic [PC_W-1:0] i_br_off,
    input  logic [PC_W-1:0] i_j_addr,
    output logic [PC_W-1:0] o_pc_next
);

    always_comb begin
        o_pc_next = i_pc_cur;
        case (i_sel)
            SEL_SEQ:  o_pc_next = i_pc_cur + PC_W'(1);
            SEL_BR:   o_pc_next = i_pc_cur + i_br_off;
            SEL_JMP:  o_pc_next = i_j_addr;
            default:  o_pc_next = i_pc_cur;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM (IF/ID/EX/MEM/WB/HALT) driving the
// PC register's next value and load enable plus IR/RF/MEM write strobes.
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset (overrides stall)
//   bus     : pc_sequencer_if.master (opcode, zero, stall, pc_cur, br_off,
//             j_addr in; pc_next, pc_we, ir_we, rf_we, mem_we, state, halt out)
//   retired : 16-bit retired-instruction counter, present only when
//             PC_SEQ_RETIRE_CNT_EN is defined
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int OP_W = OP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_sequencer_if.master     bus
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]        retired
`endif
);

    logic [2:0]      r_state;
    logic [OP_W-1:0] r_op_q;
    logic [2:0]      w_state_nxt;
    logic            w_active;
    pc_sel_e         w_sel;
    logic            w_pc_we;
    logic            w_ir_we;
    logic            w_rf_we;
    logic            w_mem_we;

    // ID decodes the live opcode; later phases decode the captured r_op_q.
    always_comb begin
        w_state_nxt = ST_IF;
        case (r_state)
            ST_IF:  w_state_nxt = ST_ID;
            ST_ID: begin
                case (bus.opcode)
                    OP_HALT:                              w_state_nxt = ST_HALT;
                    OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ:  w_state_nxt = ST_EX;
                    default:                              w_state_nxt = ST_IF;
                endcase
            end
            ST_EX: begin
                case (r_op_q)
                    OP_R, OP_ADDI: w_state_nxt = ST_WB;
                    OP_LW, OP_SW:  w_state_nxt = ST_MEM;
                    default:       w_state_nxt = ST_IF;
                endcase
            end
            ST_MEM:  w_state_nxt = (r_op_q == OP_LW) ? ST_WB : ST_IF;
            ST_WB:   w_state_nxt = ST_IF;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IF;
        endcase
    end

    // Reset and stall both suppress every write strobe and hold pc_next at pc_cur.
    assign w_active = rst_n & ~bus.stall;

    always_comb begin
        w_sel    = SEL_HOLD;
        w_pc_we  = 1'b0;
        w_ir_we  = 1'b0;
        w_rf_we  = 1'b0;
        w_mem_we = 1'b0;
        if (w_active) begin
            case (r_state)
                ST_IF: begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_sel   = SEL_SEQ;
                end
                ST_ID: begin
                    if (bus.opcode == OP_J) begin
                        w_pc_we = 1'b1;
                        w_sel   = SEL_JMP;
                    end
                end
                ST_EX: begin
                    if (r_op_q == OP_BEQ && bus.zero) begin
                        w_pc_we = 1'b1;
                        w_sel   = SEL_BR;
                    end
                end
                ST_MEM:  w_mem_we = (r_op_q == OP_SW);
                ST_WB:   w_rf_we  = 1'b1;
                default: ;
            endcase
        end
    end

    pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
        .i_sel     (w_sel),
        .i_pc_cur  (bus.pc_cur),
        .i_br_off  (bus.br_off),
        .i_j_addr  (bus.j_addr),
        .o_pc_next (bus.pc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IF;
            r_op_q  <= '0;
        end else if (!bus.stall) begin
            r_state <= w_state_nxt;
            if (r_state == ST_ID) begin
                r_op_q <= bus.opcode;
            end
        end
    end

    assign bus.pc_we  = w_pc_we;
    assign bus.ir_we  = w_ir_we;
    assign bus.rf_we  = w_rf_we;
    assign bus.mem_we = w_mem_we;
    assign bus.state  = r_state;
    assign bus.halt   = rst_n & (r_state == ST_HALT);

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic        w_retire;
    logic [15:0] r_retired;

    // Retirement = final phase of an instruction heading back to IF.
    assign w_retire = (w_state_nxt == ST_IF) &&
                      (r_state == ST_ID || r_state == ST_EX ||
                       r_state == ST_MEM || r_state == ST_WB);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (!bus.stall && w_retire) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. Stimulus pushes the
// hand-computed expected outputs for each cycle; a monitor pops and compares
// on the falling edge.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(6), .OP_W(6)) bus ();

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    pc_sequencer #(.PC_W(6), .OP_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef PC_SEQ_RETIRE_CNT_EN
        ,
        .retired (retired)
`endif
    );

    typedef struct {
        string       nm;
        logic [2:0]  st;
        logic [5:0]  pn;
        logic [3:0]  we;   // {pc_we, ir_we, rf_we, mem_we}
        logic        h;
        int unsigned ret;
    } exp_t;

    exp_t        q[$];
    int unsigned exp_ret = 0;
    int unsigned checks  = 0;
    int unsigned errors  = 0;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_IF   = 4'b1100;
    localparam logic [3:0] WE_PC   = 4'b1000;
    localparam logic [3:0] WE_RF   = 4'b0010;
    localparam logic [3:0] WE_MEM  = 4'b0001;

    task automatic cyc(input string nm, input logic [5:0] op, input logic z,
                       input logic stl, input logic [5:0] pc,
                       input logic [2:0] es, input logic [5:0] epn,
                       input logic [3:0] ewe, input logic eh, input bit ret);
        exp_t e;
        bus.opcode = op;
        bus.zero   = z;
        bus.stall  = stl;
        bus.pc_cur = pc;
        e.nm  = nm;
        e.st  = es;
        e.pn  = epn;
        e.we  = ewe;
        e.h   = eh;
        e.ret = exp_ret;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!rst_n) exp_ret = 0;
        else if (ret) exp_ret = exp_ret + 1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] got_we;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                got_we = {bus.pc_we, bus.ir_we, bus.rf_we, bus.mem_we};
                checks++;
                if (bus.state !== e.st || bus.pc_next !== e.pn ||
                    got_we !== e.we || bus.halt !== e.h) begin
                    errors++;
                    $display("FAIL %s: got state=%0d pc_next=%0d we=%b halt=%b, expected state=%0d pc_next=%0d we=%b halt=%b",
                             e.nm, bus.state, bus.pc_next, got_we, bus.halt,
                             e.st, e.pn, e.we, e.h);
                end
`ifdef PC_SEQ_RETIRE_CNT_EN
                checks++;
                if (retired !== 16'(e.ret)) begin
                    errors++;
                    $display("FAIL %s.retired: got %0d, expected %0d", e.nm, retired, e.ret);
                end
`endif
            end
        end
    end

    initial begin : stim
        rst_n       = 1'b0;
        bus.opcode  = OP_R;
        bus.zero    = 1'b0;
        bus.stall   = 1'b0;
        bus.pc_cur  = 6'd0;
        bus.br_off  = 6'h3E;
        bus.j_addr  = 6'd42;
        @(posedge clk);
        #1;
        // reset held: state IF, no writes, pc_next follows pc_cur
        cyc("rst",      OP_R, 0, 0, 6'd9,  ST_IF,  6'd9,  WE_NONE, 0, 0);
        rst_n = 1'b1;

        // R-type: IF, ID, EX, WB
        cyc("r_if",     OP_R, 0, 0, 6'd0,  ST_IF,  6'd1,  WE_IF,   0, 0);
        cyc("r_id",     OP_R, 0, 0, 6'd1,  ST_ID,  6'd1,  WE_NONE, 0, 0);
        cyc("r_ex",     OP_R, 0, 0, 6'd1,  ST_EX,  6'd1,  WE_NONE, 0, 0);
        cyc("r_wb",     OP_R, 0, 0, 6'd1,  ST_WB,  6'd1,  WE_RF,   0, 1);

        // BEQ taken: 5 + (-2) = 3
        cyc("beq_if",   OP_BEQ, 0, 0, 6'd4, ST_IF, 6'd5,  WE_IF,   0, 0);
        cyc("beq_id",   OP_BEQ, 0, 0, 6'd5, ST_ID, 6'd5,  WE_NONE, 0, 0);
        cyc("beq_ex_t", OP_BEQ, 1, 0, 6'd5, ST_EX, 6'd3,  WE_PC,   0, 1);
        // BEQ not taken
        cyc("beq_if2",  OP_BEQ, 0, 0, 6'd3, ST_IF, 6'd4,  WE_IF,   0, 0);
        cyc("beq_id2",  OP_BEQ, 0, 0, 6'd4, ST_ID, 6'd4,  WE_NONE, 0, 0);
        cyc("beq_ex_n", OP_BEQ, 0, 0, 6'd4, ST_EX, 6'd4,  WE_NONE, 0, 1);

        // J to 42
        cyc("j_if",     OP_J, 0, 0, 6'd4,  ST_IF,  6'd5,  WE_IF,   0, 0);
        cyc("j_id",     OP_J, 0, 0, 6'd5,  ST_ID,  6'd42, WE_PC,   0, 1);

        // IF stalled, then IF at 1
        cyc("if_stall", OP_LW, 0, 1, 6'd1, ST_IF,  6'd1,  WE_NONE, 0, 0);
        // LW with pc wrap 63 -> 0; opcode changed in EX must not matter
        cyc("lw_if",    OP_LW, 0, 0, 6'd63, ST_IF, 6'd0,  WE_IF,   0, 0);
        cyc("lw_id",    OP_LW, 0, 0, 6'd0, ST_ID,  6'd0,  WE_NONE, 0, 0);
        cyc("lw_ex",    OP_J,  0, 0, 6'd0, ST_EX,  6'd0,  WE_NONE, 0, 0);
        cyc("lw_mem_s1", OP_J, 0, 1, 6'd0, ST_MEM, 6'd0,  WE_NONE, 0, 0);
        cyc("lw_mem_s2", OP_J, 0, 1, 6'd0, ST_MEM, 6'd0,  WE_NONE, 0, 0);
        cyc("lw_mem_s3", OP_J, 0, 1, 6'd0, ST_MEM, 6'd0,  WE_NONE, 0, 0);
        cyc("lw_mem",   OP_J,  0, 0, 6'd0, ST_MEM, 6'd0,  WE_NONE, 0, 0);
        cyc("lw_wb",    OP_J,  0, 0, 6'd0, ST_WB,  6'd0,  WE_RF,   0, 1);

        // SW interrupted by reset in MEM
        cyc("sw_if",    OP_SW, 0, 0, 6'd2, ST_IF,  6'd3,  WE_IF,   0, 0);
        cyc("sw_id",    OP_SW, 0, 0, 6'd3, ST_ID,  6'd3,  WE_NONE, 0, 0);
        cyc("sw_ex",    OP_SW, 0, 0, 6'd3, ST_EX,  6'd3,  WE_NONE, 0, 0);
        rst_n = 1'b0;
        cyc("sw_mem_rst", OP_SW, 0, 0, 6'd3, ST_MEM, 6'd3, WE_NONE, 0, 0);
        rst_n = 1'b1;
        // refetch at current pc, complete SW
        cyc("sw_if_re", OP_SW, 0, 0, 6'd3, ST_IF,  6'd4,  WE_IF,   0, 0);
        cyc("sw_id_re", OP_SW, 0, 0, 6'd4, ST_ID,  6'd4,  WE_NONE, 0, 0);
        cyc("sw_ex_re", OP_SW, 0, 0, 6'd4, ST_EX,  6'd4,  WE_NONE, 0, 0);
        cyc("sw_mem",   OP_SW, 0, 0, 6'd4, ST_MEM, 6'd4,  WE_MEM,  0, 1);

        // Unknown opcode behaves as NOP
        cyc("nop_if",   6'h3A, 0, 0, 6'd4, ST_IF,  6'd5,  WE_IF,   0, 0);
        cyc("nop_id",   6'h3A, 1, 0, 6'd5, ST_ID,  6'd5,  WE_NONE, 0, 1);

        // HALT: parks in state 5, no writes
        cyc("halt_if",  OP_HALT, 0, 0, 6'd5, ST_IF, 6'd6, WE_IF,   0, 0);
        cyc("halt_id",  OP_HALT, 0, 0, 6'd6, ST_ID, 6'd6, WE_NONE, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc("halt_hold", OP_HALT, 1'(i), 0, 6'd6, ST_HALT, 6'd6, WE_NONE, 1, 0);
        end
        rst_n = 1'b0;
        cyc("halt_rst", OP_HALT, 0, 0, 6'd6, ST_HALT, 6'd6, WE_NONE, 0, 0);
        cyc("halt_out", OP_HALT, 0, 0, 6'd6, ST_IF,   6'd6, WE_NONE, 0, 0);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
